// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the serial add/subtract unit.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int steps(input int width, input int digit);
      return width / digit;
   endfunction

   // Enough bits to hold 0..n_steps, never narrower than one bit.
   function automatic int cnt_w(input int n_steps);
      return (n_steps < 1) ? 1 : $clog2(n_steps + 1);
   endfunction

endpackage

// File: rtl/fa_digit.sv
// DIGIT-bit combinational ripple adder built from half-adder pairs; also
// exposes the carry into its top bit so the caller can derive overflow.
module fa_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             c_msb_in
);

   logic [DIGIT:0]   c;
   logic [DIGIT-1:0] p;
   logic [DIGIT-1:0] g;
   logic [DIGIT-1:0] t;

   assign c[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      assign p[i]   = a[i] ^ b[i];
      assign g[i]   = a[i] & b[i];
      assign s[i]   = p[i] ^ c[i];
      assign t[i]   = p[i] & c[i];
      assign c[i+1] = g[i] | t[i];
   end

   assign cout     = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract unit: DIGIT bits per clock, LSB first, with the
// inter-digit carry held in a flip-flop and a start/done handshake.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STEPS = steps(WIDTH, DIGIT);
   localparam int CW    = cnt_w(STEPS);
   localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

   if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [CW-1:0]    step;

   logic                   accept;
   logic                   last_step;
   logic [DIGIT-1:0]       dig_s;
   logic                   dig_cout;
   logic                   dig_c_msb;
   logic [WIDTH+DIGIT-1:0] sum_cat;

   fa_digit #(.DIGIT(DIGIT)) u_digit (
      .a        (op_a[DIGIT-1:0]),
      .b        (op_b[DIGIT-1:0]),
      .cin      (carry),
      .s        (dig_s),
      .cout     (dig_cout),
      .c_msb_in (dig_c_msb)
   );

   // A new request is taken whenever no computation is running, including
   // the done cycle, so back-to-back operations need no idle gap.
   assign accept    = start && (state != RUN);
   assign last_step = (step == LAST_STEP);
   assign sum_cat   = {dig_s, sum};

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_step) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operands drain LSB-first while result digits enter sum from the top,
   // so after STEPS shifts sum holds the full result in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a  <= '0;
         op_b  <= '0;
         carry <= 1'b0;
         step  <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         op_a  <= a;
         op_b  <= sub ? ~b : b;
         carry <= sub ? 1'b1 : cin;
         step  <= '0;
      end else if (state == RUN) begin
         op_a  <= op_a >> DIGIT;
         op_b  <= op_b >> DIGIT;
         carry <= dig_cout;
         sum   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
         step  <= step + CW'(1);
         if (last_step) begin
            cout <= dig_cout;
            ovf  <= dig_c_msb ^ dig_cout;
         end
      end
   end

endmodule
